// File: rtl/seq_ff_pkg.sv
// Shared definitions for the universal flip-flop bank.
//   ff_mode_t : 2-bit runtime mode select (JK, SR, T, D); every encoding is legal.
package seq_ff_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'd0,
        MODE_SR = 2'd1,
        MODE_T  = 2'd2,
        MODE_D  = 2'd3
    } ff_mode_t;

endpackage

// File: rtl/seq_univ_ff_cell.sv
// One flip-flop channel: combinational next-state and illegal-SR detect.
// Ports:
//   mode    - shared mode select
//   a_i     - primary input (J, S, T or D)
//   b_i     - secondary input (K or R); unused in T and D modes
//   c       - current state of this bit
//   n       - next state of this bit
//   illegal - S=R=1 presented in SR mode
module seq_univ_ff_cell
    import seq_ff_pkg::*;
(
    input  ff_mode_t mode,
    input  logic     a_i,
    input  logic     b_i,
    input  logic     c,
    output logic     n,
    output logic     illegal
);

    always_comb begin
        n       = c;
        illegal = 1'b0;
        // b_i is only read inside the JK and SR arms so an X on it cannot
        // reach n in T or D mode.
        case (mode)
            MODE_JK: begin
                case ({a_i, b_i})
                    2'b01:   n = 1'b0;
                    2'b10:   n = 1'b1;
                    2'b11:   n = ~c;
                    default: n = c;
                endcase
            end
            MODE_SR: begin
                case ({a_i, b_i})
                    2'b01:   n = 1'b0;
                    2'b10:   n = 1'b1;
                    2'b11: begin
                        n       = c;
                        illegal = 1'b1;
                    end
                    default: n = c;
                endcase
            end
            MODE_T:  n = a_i ? ~c : c;
            MODE_D:  n = a_i;
            default: n = c;
        endcase
    end

endmodule

// File: rtl/seq_univ_ff_bank.sv
// Bank of NBITS independent flip-flops sharing one runtime mode (JK/SR/T/D).
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset; loads RESET_VAL, clears chg/err
//   mode    - 0=JK 1=SR 2=T 3=D, applies to all bits
//   en      - clock enable; 0 freezes q and err, forces chg to 0
//   a, b    - per-bit inputs (J/S/T/D and K/R)
//   err_clr - clears sticky error bits (honoured regardless of en)
//   q       - flip-flop state
//   chg     - bit i set iff q[i] changed on the previous edge
//   err     - sticky illegal-SR flag per bit
module seq_univ_ff_bank
    import seq_ff_pkg::*;
#(
    parameter int unsigned     NBITS     = 4,
    parameter logic [NBITS-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             err_clr,
    output logic [NBITS-1:0] q,
    output logic [NBITS-1:0] chg,
    output logic [NBITS-1:0] err
);

    logic [NBITS-1:0] q_q, q_d;
    logic [NBITS-1:0] chg_q, chg_d;
    logic [NBITS-1:0] err_q, err_d;
    logic [NBITS-1:0] n_vec;
    logic [NBITS-1:0] illegal_vec;

    for (genvar i = 0; i < NBITS; i++) begin : g_cell
        seq_univ_ff_cell u_cell (
            .mode    (ff_mode_t'(mode)),
            .a_i     (a[i]),
            .b_i     (b[i]),
            .c       (q_q[i]),
            .n       (n_vec[i]),
            .illegal (illegal_vec[i])
        );
    end

    always_comb begin
        q_d   = q_q;
        chg_d = '0;
        err_d = err_q;
        if (en) begin
            q_d   = n_vec;
            chg_d = n_vec ^ q_q;
        end
        if (err_clr) begin
            err_d = '0;
        end
        // A fresh illegal-SR event wins over a same-cycle clear.
        if (en) begin
            err_d = err_d | illegal_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= RESET_VAL;
            chg_q <= '0;
            err_q <= '0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            err_q <= err_d;
        end
    end

    assign q   = q_q;
    assign chg = chg_q;
    assign err = err_q;

endmodule

// File: tb/tb_seq_univ_ff_bank.sv
module tb_seq_univ_ff_bank;

    localparam int unsigned NB = 4;
    localparam logic [NB-1:0] RV = 4'b0101;

    logic          clk;
    logic          reset;
    logic [1:0]    mode;
    logic          en;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          err_clr;
    logic [NB-1:0] q;
    logic [NB-1:0] chg;
    logic [NB-1:0] err;

    seq_univ_ff_bank #(
        .NBITS     (NB),
        .RESET_VAL (RV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .en      (en),
        .a       (a),
        .b       (b),
        .err_clr (err_clr),
        .q       (q),
        .chg     (chg),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          en;
        logic [1:0]    mode;
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic          clr;
        logic [NB-1:0] eq;
        logic [NB-1:0] echg;
        logic [NB-1:0] eerr;
    } vec_t;

    typedef struct {
        int            tag;
        logic [NB-1:0] eq;
        logic [NB-1:0] echg;
        logic [NB-1:0] eerr;
    } exp_t;

    vec_t tbl[18];
    exp_t sb[$];
    int   n_vec;
    int   n_bad;

    // Reference next-state from the characteristic equations.
    function automatic logic [NB-1:0] ref_next(input logic [1:0] md, input logic [NB-1:0] ai,
                                               input logic [NB-1:0] bi, input logic [NB-1:0] ci);
        case (md)
            2'd0:    return (ai & ~ci) | (~bi & ci);
            2'd1:    return (ai & ~bi) | (ci & ~(ai ^ bi));
            2'd2:    return ci ^ ai;
            default: return ai;
        endcase
    endfunction

    task automatic apply(input vec_t v, input int tag);
        exp_t e;
        @(negedge clk);
        reset   = v.rst;
        en      = v.en;
        mode    = v.mode;
        a       = v.a;
        b       = v.b;
        err_clr = v.clr;
        e.tag  = tag;
        e.eq   = v.eq;
        e.echg = v.echg;
        e.eerr = v.eerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: no expected entry queued");
            n_bad++;
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (q !== e.eq) begin
            $display("FAIL v%0d q: got %h want %h", e.tag, q, e.eq);
            n_bad++;
        end
        if (chg !== e.echg) begin
            $display("FAIL v%0d chg: got %h want %h", e.tag, chg, e.echg);
            n_bad++;
        end
        if (err !== e.eerr) begin
            $display("FAIL v%0d err: got %h want %h", e.tag, err, e.eerr);
            n_bad++;
        end
    endtask

    initial begin
        logic [NB-1:0] mq, mchg, merr, nx, ill;
        vec_t          v;

        n_vec   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        en      = 1'b0;
        mode    = 2'd0;
        a       = '0;
        b       = '0;
        err_clr = 1'b0;

        //          rst   en    mode  a      b        clr   q      chg    err
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'h0, 4'h0,    1'b0, 4'h5, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 4'hF, 4'hF,    1'b0, 4'h5, 4'h0, 4'h0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 4'hF, 4'hF,    1'b0, 4'h5, 4'h0, 4'h0};
        tbl[3]  = '{1'b0, 1'b1, 2'd0, 4'hC, 4'hA,    1'b0, 4'hD, 4'h8, 4'h0};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 4'hC, 4'hA,    1'b0, 4'h5, 4'h8, 4'h0};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, 4'h3, 4'h1,    1'b0, 4'h7, 4'h2, 4'h1};
        tbl[6]  = '{1'b0, 1'b1, 2'd1, 4'h0, 4'h0,    1'b1, 4'h7, 4'h0, 4'h0};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 4'h8, 4'h8,    1'b1, 4'h7, 4'h0, 4'h8};
        tbl[8]  = '{1'b0, 1'b1, 2'd3, 4'h5, 4'h0,    1'b1, 4'h5, 4'h2, 4'h0};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, 4'hF, 4'bxxxx, 1'b0, 4'hA, 4'hF, 4'h0};
        tbl[10] = '{1'b0, 1'b1, 2'd2, 4'hF, 4'bxxxx, 1'b0, 4'h5, 4'hF, 4'h0};
        tbl[11] = '{1'b0, 1'b1, 2'd2, 4'hF, 4'bxxxx, 1'b0, 4'hA, 4'hF, 4'h0};
        tbl[12] = '{1'b0, 1'b1, 2'd3, 4'h3, 4'h0,    1'b0, 4'h3, 4'h9, 4'h0};
        tbl[13] = '{1'b1, 1'b1, 2'd3, 4'hE, 4'h0,    1'b0, 4'h5, 4'h0, 4'h0};
        tbl[14] = '{1'b0, 1'b1, 2'd3, 4'hE, 4'h0,    1'b0, 4'hE, 4'hB, 4'h0};
        // en=0 with S=R=1 must not set err.
        tbl[15] = '{1'b0, 1'b0, 2'd1, 4'hF, 4'hF,    1'b0, 4'hE, 4'h0, 4'h0};
        tbl[16] = '{1'b0, 1'b1, 2'd1, 4'h1, 4'h1,    1'b0, 4'hE, 4'h0, 4'h1};
        // err_clr still honoured while en=0.
        tbl[17] = '{1'b0, 1'b0, 2'd1, 4'h0, 4'h0,    1'b1, 4'hE, 4'h0, 4'h0};

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i], i);
        end

        // Randomised section against the reference equations.
        mq   = tbl[17].eq;
        merr = tbl[17].eerr;
        for (int i = 0; i < 60; i++) begin
            v.rst  = ($urandom_range(0, 15) == 0);
            v.en   = ($urandom_range(0, 3) != 0);
            v.mode = 2'($urandom_range(0, 3));
            v.a    = NB'($urandom);
            v.b    = NB'($urandom);
            v.clr  = ($urandom_range(0, 5) == 0);
            if (v.rst) begin
                mq   = RV;
                mchg = '0;
                merr = '0;
            end else begin
                nx   = v.en ? ref_next(v.mode, v.a, v.b, mq) : mq;
                ill  = (v.en && v.mode == 2'd1) ? (v.a & v.b) : '0;
                mchg = nx ^ mq;
                merr = (v.clr ? '0 : merr) | ill;
                mq   = nx;
            end
            v.eq   = mq;
            v.echg = mchg;
            v.eerr = merr;
            apply(v, 100 + i);
        end

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_residue: %0d entries left, want 0", sb.size());
            n_bad++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
